// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a two-entry skid buffer, a registered in_ready,
// a flush that keeps only the KEEP_MASK bits of the main register, and a saturating stall counter.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_EMPTY | main and skid registers both invalid
//   ST_FULL  | main register valid, skid register invalid
//   ST_SKID  | main and skid registers both valid
module pipe_stage_skid #(
    parameter int unsigned         WIDTH     = 300,
    parameter logic [WIDTH-1:0]    KEEP_MASK = {{(WIDTH-64){1'b0}}, 32'hFFFF_FFFF, 32'h0000_0000},
    parameter int unsigned         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = m_q;
    assign stall_cnt = stall_cnt_q;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;

        if (flush) begin
            // Any word accepted this cycle is dropped; the PC field survives in M.
            state_d = ST_EMPTY;
            m_d     = m_q & KEEP_MASK;
            s_d     = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                        m_d     = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        m_d = in_data;
                    end else if (in_xfer) begin
                        state_d = ST_SKID;
                        s_d     = in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d = ST_FULL;
                        m_d     = s_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d = (state_d != ST_SKID);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
